prll_bs_trmnl: RTL and testbench
================================

# prll_bs_trmnl

Terminal-side endpoint for the parallel bus generator/arbiter: one instance per driver per bus. It buffers host transmit words in a show-ahead FIFO, which it presents to the bus as `pndng`/`D_pop` and drains on `pop`. It also accepts bus deliveries on `push`/`D_push` into a receive FIFO with destination filtering and overflow accounting. It closes the loop that the bus system leaves open at each terminal.

## Interface
- `BITS`, 32: word width; layout [BITS-1:BITS-8] target, [BITS-9:BITS-16] source, [BITS-17:0] payload/ID.
- `DEPTH`, 16: entries per FIFO; power of two, ≥2.
- `ID`, 8'h00: this terminal's address.
- `BROADCAST`, 8'hFF: broadcast target address.
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  host offers a word.
- `tx_data`  in  BITS  host word; its source field is ignored.
- `tx_ready`  out  1  tx FIFO not full.
- `pndng`  out  1  tx FIFO not empty (to bus).
- `D_pop`  out  BITS  tx FIFO head word (to bus).
- `pop`  in  1  bus consumes head.
- `push`  in  1  bus delivers a word.
- `D_push`  in  BITS  delivered word.
- `rx_valid`  out  1  rx FIFO not empty.
- `rx_data`  out  BITS  rx FIFO head word.
- `rx_rd`  in  1  host consumes rx head.
- `rx_ovf`  out  1  sticky: a push was lost to a full rx FIFO.
- `rx_drop_cnt`  out  8  saturating count of lost plus filtered words.
- `tx_count`, `rx_count`  out  $clog2(DEPTH+1)  occupancy.

## Operation
- TX write: when `tx_valid && tx_ready`, store the word with bits [BITS-9:BITS-16] replaced by `ID`. Target and payload are stored unchanged.
- TX read: `D_pop` is the head word, combinational from storage. `pop && pndng` advances the head. `pop` while empty is ignored with no state change.
- RX write: on `push`, accept the word if rx is not full, or if rx is full and `rx_rd` is asserted in the same cycle. Otherwise drop the word, set `rx_ovf`, and increment `rx_drop_cnt`.
- RX read: `rx_rd && rx_valid` advances the head. `rx_rd` while empty is ignored.
- `rx_ovf` is cleared only by reset. `rx_drop_cnt` saturates at 255.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from the occupancy counter, not from pointer equality.
- Same-cycle write and read on either FIFO: the count is unchanged and both pointers advance.

## Timing
- Reset, asynchronous: pointers and counts go to 0. Outputs: `pndng`=0, `tx_ready`=1, `rx_valid`=0, `rx_ovf`=0, `rx_drop_cnt`=0. `D_pop`/`rx_data` are don't-care, 0 in the model.
- Latency: a word written at edge N gives `pndng`/`rx_valid`=1 after edge N, i.e. visible in cycle N+1. There is no bypass from `tx_data` to `D_pop`.
- `tx_ready` is `!full`, registered-state only. A write while full with a same-cycle `pop` is still refused.
- Reset asserted mid-operation discards both FIFOs' contents immediately.

## Configuration
- `PRLL_BS_TRMNL_ADDR_FILTER_EN` defined: an rx word is accepted only if its target equals `ID` or `BROADCAST`. Any other word is discarded and increments `rx_drop_cnt`, but does not set `rx_ovf`.
- Undefined: every pushed word goes through the full/overflow rules only.

## Structure
- Package `prll_bs_pkg` holds:
  - the `BROADCAST` default;
  - field offset constants (TGT_MSB, SRC_MSB, ID_MSB);
  - packed struct `prll_bs_msg_t` {target, source, id}.
- Sub-module `prll_bs_sync_fifo` (show-ahead, occupancy count, `full`/`empty`) is instantiated twice.
- Source stamping, drop accounting and the filter live in the top module.

## Test plan
- Reset, then 3 host writes 32'h0100_0005, 32'h0100_0006 and 32'h0100_0007 with `ID`=8'h02:
  - `pndng`=1 one cycle after the first write;
  - `D_pop`=32'h0102_0005 at the head;
  - pops return the words in order; after the 3rd pop, `pndng`=0 and `tx_count`=0.
- Fill tx to `DEPTH` → `tx_ready`=0 and the 17th write is refused. Pop once → `tx_ready`=1 next cycle.
- Push 17 words with no `rx_rd` (DEPTH=16) → `rx_count`=16, `rx_ovf`=1, `rx_drop_cnt`=1. The first 16 words read back in order.
- With the rx FIFO full, assert `push` and `rx_rd` in the same cycle → the word is accepted, `rx_count` stays 16, and `rx_drop_cnt` is unchanged.
- Macro defined, `ID`=8'h01: push targets 8'h01, 8'h03 and 8'hFF → 2 words stored, `rx_drop_cnt`=1, `rx_ovf`=0.
- Assert reset with 5 words in each FIFO → all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prll_bs_pkg.sv
// Shared constants and message layout for the parallel-bus terminal.
package prll_bs_pkg;

  localparam logic [7:0] BROADCAST_DEFAULT = 8'hFF;

  // Field MSBs for the default 32-bit word layout.
  localparam int TGT_MSB = 31;
  localparam int SRC_MSB = 23;
  localparam int ID_MSB  = 15;

  typedef struct packed {
    logic [7:0]  target;
    logic [7:0]  source;
    logic [15:0] id;
  } prll_bs_msg_t;

endpackage

// File: rtl/prll_bs_sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty derive from the occupancy counter.
module prll_bs_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == {CW{1'b0}});
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is only legal when the head leaves the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? {W{1'b0}} : mem[rd_ptr];

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prll_bs_trmnl.sv
// Parallel-bus terminal endpoint: tx FIFO toward the bus, rx FIFO from it.
// Optional build macro PRLL_BS_TRMNL_ADDR_FILTER_EN enables rx destination filtering.
module prll_bs_trmnl
  import prll_bs_pkg::*;
#(
  parameter int         BITS      = 32,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] ID        = 8'h00,
  parameter logic [7:0] BROADCAST = BROADCAST_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tx_valid,
  input  logic [BITS-1:0]             tx_data,
  output logic                        tx_ready,
  output logic                        pndng,
  output logic [BITS-1:0]             D_pop,
  input  logic                        pop,
  input  logic                        push,
  input  logic [BITS-1:0]             D_push,
  output logic                        rx_valid,
  output logic [BITS-1:0]             rx_data,
  input  logic                        rx_rd,
  output logic                        rx_ovf,
  output logic [7:0]                  rx_drop_cnt,
  output logic [$clog2(DEPTH+1)-1:0]  tx_count,
  output logic [$clog2(DEPTH+1)-1:0]  rx_count
);

`ifdef PRLL_BS_TRMNL_ADDR_FILTER_EN
  localparam logic FILT_EN = 1'b1;
`else
  localparam logic FILT_EN = 1'b0;
`endif

  localparam logic [BITS-1:0] SRC_MASK = {8'h00, 8'hFF, {(BITS-16){1'b0}}};

  logic            tx_full;
  logic            tx_empty;
  logic            tx_wr;
  logic [BITS-1:0] tx_word;
  logic            rx_full;
  logic            rx_empty;
  logic [7:0]      rx_tgt;
  logic            addr_ok;
  logic            rx_room;
  logic            rx_wr;
  logic            rx_lost;
  logic            rx_drop;

  // Source field is overwritten with this terminal's address.
  assign tx_word  = (tx_data & ~SRC_MASK) | ({{(BITS-8){1'b0}}, ID} << (BITS-16));
  assign tx_wr    = tx_valid && !tx_full;
  assign tx_ready = !tx_full;
  assign pndng    = !tx_empty;

  assign rx_tgt   = D_push[BITS-1:BITS-8];
  assign addr_ok  = !FILT_EN || (rx_tgt == ID) || (rx_tgt == BROADCAST);
  assign rx_room  = !rx_full || rx_rd;
  assign rx_wr    = push && addr_ok && rx_room;
  assign rx_lost  = push && addr_ok && !rx_room;
  assign rx_drop  = rx_lost || (push && !addr_ok);
  assign rx_valid = !rx_empty;

  prll_bs_sync_fifo #(.W(BITS), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_wr),
    .wr_data (tx_word),
    .rd_en   (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  prll_bs_sync_fifo #(.W(BITS), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_wr),
    .wr_data (D_push),
    .rd_en   (rx_rd),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ovf      <= 1'b0;
      rx_drop_cnt <= 8'd0;
    end else begin
      if (rx_lost) begin
        rx_ovf <= 1'b1;
      end
      if (rx_drop && (rx_drop_cnt != 8'hFF)) begin
        rx_drop_cnt <= rx_drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_prll_bs_trmnl.sv
// Directed, scoreboard-based bench for prll_bs_trmnl (BITS=32, DEPTH=16, ID=8'h02).
module tb_prll_bs_trmnl;

  localparam int         BITS  = 32;
  localparam int         DEPTH = 16;
  localparam logic [7:0] MY_ID = 8'h02;

  logic        clk;
  logic        rst_n;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        pndng;
  logic [31:0] D_pop;
  logic        pop;
  logic        push;
  logic [31:0] D_push;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_rd;
  logic        rx_ovf;
  logic [7:0]  rx_drop_cnt;
  logic [4:0]  tx_count;
  logic [4:0]  rx_count;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  prll_bs_trmnl #(.BITS(BITS), .DEPTH(DEPTH), .ID(MY_ID), .BROADCAST(8'hFF)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_rd       (rx_rd),
    .rx_ovf      (rx_ovf),
    .rx_drop_cnt (rx_drop_cnt),
    .tx_count    (tx_count),
    .rx_count    (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stamp(input logic [31:0] w);
    return {w[31:24], MY_ID, w[15:0]};
  endfunction

  task automatic tx_write(input logic [31:0] w);
    tx_valid = 1'b1;
    tx_data  = w;
    tx_q.push_back(stamp(w));
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic tx_pop_check(input string tag);
    logic [31:0] e;
    e = tx_q.pop_front();
    check(tag, D_pop, e);
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic rx_push(input logic [31:0] w, input logic keep);
    push   = 1'b1;
    D_push = w;
    if (keep) rx_q.push_back(w);
    tick();
    push = 1'b0;
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] e;
    e = rx_q.pop_front();
    check(tag, rx_data, e);
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 32'd0; pop = 1'b0;
    push = 1'b0; D_push = 32'd0; rx_rd = 1'b0;
    #1;
    check("rst_pndng",    {31'd0, pndng},    32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_ovf",   {31'd0, rx_ovf},   32'd0);
    check("rst_drop",     {24'd0, rx_drop_cnt}, 32'd0);
    check("rst_tx_count", {27'd0, tx_count}, 32'd0);
    check("rst_rx_count", {27'd0, rx_count}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic tx: stamping, latency, order.
    tx_write(32'h0100_0005);
    check("tx_pndng_latency", {31'd0, pndng}, 32'd1);
    tx_write(32'h0100_0006);
    tx_write(32'h0100_0007);
    check("tx_head_stamped", D_pop, 32'h0102_0005);
    check("tx_count3", {27'd0, tx_count}, 32'd3);
    for (int i = 0; i < 3; i++) tx_pop_check("tx_pop_order");
    check("tx_pndng_empty", {31'd0, pndng}, 32'd0);
    check("tx_count_empty", {27'd0, tx_count}, 32'd0);
    pop = 1'b1; tick(); pop = 1'b0;
    check("tx_pop_empty_ignored", {27'd0, tx_count}, 32'd0);

    // tx full, refused writes.
    for (int i = 0; i < DEPTH; i++) tx_write({8'h05 + 8'(i), 8'hAA, 16'h1000 + 16'(i)});
    check("tx_full_ready", {31'd0, tx_ready}, 32'd0);
    check("tx_full_count", {27'd0, tx_count}, 32'd16);
    tx_valid = 1'b1; tx_data = 32'hDEAD_BEEF; tick(); tx_valid = 1'b0;
    check("tx_17th_refused", {27'd0, tx_count}, 32'd16);
    // Write while full with same-cycle pop: the write is still refused.
    check("tx_full_head", D_pop, tx_q.pop_front());
    tx_valid = 1'b1; tx_data = 32'hCAFE_0001; pop = 1'b1; tick();
    tx_valid = 1'b0; pop = 1'b0;
    check("tx_full_wr_pop_count", {27'd0, tx_count}, 32'd15);
    check("tx_ready_after_pop", {31'd0, tx_ready}, 32'd1);
    while (tx_q.size() > 0) tx_pop_check("tx_drain_order");
    check("tx_drained_pndng", {31'd0, pndng}, 32'd0);

    // rx overflow.
    for (int i = 0; i < DEPTH + 1; i++) rx_push({MY_ID, 8'h30, 16'h2000 + 16'(i)}, i < DEPTH);
    check("rx_full_count", {27'd0, rx_count}, 32'd16);
    check("rx_ovf_set",    {31'd0, rx_ovf},   32'd1);
    check("rx_drop_one",   {24'd0, rx_drop_cnt}, 32'd1);
    // Full with simultaneous read: push accepted, nothing dropped.
    check("rx_full_head", rx_data, rx_q.pop_front());
    rx_q.push_back(32'hFF40_ABCD);
    push = 1'b1; D_push = 32'hFF40_ABCD; rx_rd = 1'b1; tick();
    push = 1'b0; rx_rd = 1'b0;
    check("rx_full_rdwr_count", {27'd0, rx_count}, 32'd16);
    check("rx_full_rdwr_drop",  {24'd0, rx_drop_cnt}, 32'd1);
    while (rx_q.size() > 0) rx_read_check("rx_order");
    check("rx_drained_valid", {31'd0, rx_valid}, 32'd0);
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    check("rx_rd_empty_ignored", {27'd0, rx_count}, 32'd0);

    // Reset clears the sticky flag and counter before the filter test.
    rst_n = 1'b0; #1;
    check("rst_clears_ovf",  {31'd0, rx_ovf}, 32'd0);
    check("rst_clears_drop", {24'd0, rx_drop_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef PRLL_BS_TRMNL_ADDR_FILTER_EN
    rx_push({MY_ID, 8'h11, 16'h0001}, 1'b1);
    rx_push({8'h03, 8'h11, 16'h0002}, 1'b0);
    rx_push({8'hFF, 8'h11, 16'h0003}, 1'b1);
    check("filt_count", {27'd0, rx_count}, 32'd2);
    check("filt_drop",  {24'd0, rx_drop_cnt}, 32'd1);
    check("filt_ovf",   {31'd0, rx_ovf}, 32'd0);
`else
    rx_push({MY_ID, 8'h11, 16'h0001}, 1'b1);
    rx_push({8'h03, 8'h11, 16'h0002}, 1'b1);
    rx_push({8'hFF, 8'h11, 16'h0003}, 1'b1);
    check("nofilt_count", {27'd0, rx_count}, 32'd3);
    check("nofilt_drop",  {24'd0, rx_drop_cnt}, 32'd0);
    check("nofilt_ovf",   {31'd0, rx_ovf}, 32'd0);
`endif
    while (rx_q.size() > 0) rx_read_check("filt_order");

    // Mid-operation asynchronous reset with both FIFOs holding 5 words.
    for (int i = 0; i < 5; i++) begin
      tx_write({8'h09, 8'h00, 16'h3000 + 16'(i)});
      rx_push({MY_ID, 8'h22, 16'h4000 + 16'(i)}, 1'b1);
    end
    check("pre_rst_tx_count", {27'd0, tx_count}, 32'd5);
    check("pre_rst_rx_count", {27'd0, rx_count}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pndng",    {31'd0, pndng},    32'd0);
    check("async_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("async_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("async_tx_count", {27'd0, tx_count}, 32'd0);
    check("async_rx_count", {27'd0, rx_count}, 32'd0);
    check("async_rx_ovf",   {31'd0, rx_ovf},   32'd0);
    check("async_drop",     {24'd0, rx_drop_cnt}, 32'd0);
    tx_q.delete();
    rx_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
